// File: rtl/opt1_os_tile_ctrl.sv
// opt1_os_tile_ctrl: tile sequencer for the OPT1 output-stationary systolic
// array. One command runs CLEAR -> FEED (k_len cycles) -> FLUSH (skew plus
// PE input pipeline) -> DRAIN (one row per handshake) -> DONE. Only control
// signals are generated; operand and accumulator data never pass through here.
// Optional feature macro: OPT1_TILE_CTRL_PERF_CNT_EN builds the per-tile
// cycle and stall counters. Without it, perf_cycles and perf_stall are tied to 0.
module opt1_os_tile_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_WIDTH   = 16,
  parameter int INPUT_PIP = 1,
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_len,
  output logic               busy,
  output logic               acc_clr,
  output logic               feed_en,
  output logic [K_WIDTH-1:0] feed_k,
  output logic               drain_valid,
  input  logic               drain_ready,
  output logic [RW-1:0]      drain_row_sel,
  output logic               drain_last,
  output logic               done,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stall
);

  // The array needs ROWS+COLS-1 cycles of skew to settle, plus the PE input stage.
  localparam int FLUSH_LEN = ROWS + COLS - 1 + INPUT_PIP;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [K_WIDTH-1:0] k_len_r, k_len_nxt_s;
  logic [K_WIDTH-1:0] feed_k_r, feed_k_nxt_s;
  logic [FW-1:0]      flush_cnt_r, flush_cnt_nxt_s;
  logic [RW-1:0]      row_r, row_nxt_s;

  assign feed_k        = feed_k_r;
  assign drain_row_sel = row_r;

  // Next-state and counter updates; every register holds unless a state moves it.
  always_comb begin
    state_nxt_s     = state_r;
    k_len_nxt_s     = k_len_r;
    feed_k_nxt_s    = feed_k_r;
    flush_cnt_nxt_s = flush_cnt_r;
    row_nxt_s       = row_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s  = ST_CLEAR;
          k_len_nxt_s  = k_len;
          feed_k_nxt_s = {K_WIDTH{1'b0}};
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // A zero-length tile has nothing to stream, so go straight to flushing.
        if (k_len_r != {K_WIDTH{1'b0}}) begin
          state_nxt_s     = ST_FEED;
        end else begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = {FW{1'b0}};
        end
      end
      ST_FEED: begin
        if (feed_k_r == (k_len_r - K_WIDTH'(1))) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = {FW{1'b0}};
        end else begin
          feed_k_nxt_s    = feed_k_r + K_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FW'(FLUSH_LEN - 1)) begin
          state_nxt_s     = ST_DRAIN;
          row_nxt_s       = {RW{1'b0}};
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + FW'(1);
        end
      end
      ST_DRAIN: begin
        // drain_valid is always high in DRAIN, so drain_ready alone completes a beat.
        if (drain_ready) begin
          if (row_r == RW'(ROWS - 1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            row_nxt_s   = row_r + RW'(1);
          end
        end else begin
          row_nxt_s = row_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_len_r     <= {K_WIDTH{1'b0}};
      feed_k_r    <= {K_WIDTH{1'b0}};
      flush_cnt_r <= {FW{1'b0}};
      row_r       <= {RW{1'b0}};
      busy        <= 1'b0;
      acc_clr     <= 1'b0;
      feed_en     <= 1'b0;
      drain_valid <= 1'b0;
      drain_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      k_len_r     <= k_len_nxt_s;
      feed_k_r    <= feed_k_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      row_r       <= row_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
      acc_clr     <= (state_nxt_s == ST_CLEAR);
      feed_en     <= (state_nxt_s == ST_FEED);
      drain_valid <= (state_nxt_s == ST_DRAIN);
      drain_last  <= (state_nxt_s == ST_DRAIN) && (row_nxt_s == RW'(ROWS - 1));
      done        <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef OPT1_TILE_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt_r;
  logic [31:0] stall_cnt_r;
  logic [31:0] perf_cycles_r;
  logic [31:0] perf_stall_r;

  assign perf_cycles = perf_cycles_r;
  assign perf_stall  = perf_stall_r;

  // Count busy and backpressure cycles per tile; publish both when DONE is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_r     <= 32'd0;
      stall_cnt_r   <= 32'd0;
      perf_cycles_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if (state_r == ST_IDLE) begin
        cyc_cnt_r <= 32'd0;
      end else begin
        cyc_cnt_r <= cyc_cnt_r + 32'd1;
      end
      if (state_r == ST_CLEAR) begin
        stall_cnt_r <= 32'd0;
      end else if ((state_r == ST_DRAIN) && !drain_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      // The DONE cycle itself is part of the tile, hence the +1.
      if (state_r == ST_DONE) begin
        perf_cycles_r <= cyc_cnt_r + 32'd1;
        perf_stall_r  <= stall_cnt_r;
      end else begin
        perf_cycles_r <= perf_cycles_r;
        perf_stall_r  <= perf_stall_r;
      end
    end
  end
`else
  assign perf_cycles = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_opt1_os_tile_ctrl.sv
// Directed bench for opt1_os_tile_ctrl: default geometry (4x4, INPUT_PIP=1)
// checked cycle by cycle, plus a 2x8 INPUT_PIP=0 instance for the flush length.
module tb_opt1_os_tile_ctrl;

  localparam int ROWS0 = 4;
  localparam int F0    = 8;   // 4 + 4 - 1 + 1
`ifdef OPT1_TILE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start, drain_ready;
  logic [15:0] k_len;
  logic        busy, acc_clr, feed_en, drain_valid, drain_last, done;
  logic [15:0] feed_k;
  logic [1:0]  drain_row_sel;
  logic [31:0] perf_cycles, perf_stall;

  logic        start1, drain_ready1;
  logic [15:0] k_len1;
  logic        busy1, acc_clr1, feed_en1, drain_valid1, drain_last1, done1;
  logic [15:0] feed_k1;
  logic [0:0]  drain_row_sel1;
  logic [31:0] perf_cycles1, perf_stall1;

  int n_tests = 0;
  int n_fail  = 0;

  opt1_os_tile_ctrl #(.ROWS(4), .COLS(4), .K_WIDTH(16), .INPUT_PIP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .acc_clr(acc_clr), .feed_en(feed_en), .feed_k(feed_k),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_row_sel(drain_row_sel), .drain_last(drain_last), .done(done),
    .perf_cycles(perf_cycles), .perf_stall(perf_stall)
  );

  opt1_os_tile_ctrl #(.ROWS(2), .COLS(8), .K_WIDTH(16), .INPUT_PIP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .k_len(k_len1), .busy(busy1),
    .acc_clr(acc_clr1), .feed_en(feed_en1), .feed_k(feed_k1),
    .drain_valid(drain_valid1), .drain_ready(drain_ready1),
    .drain_row_sel(drain_row_sel1), .drain_last(drain_last1), .done(done1),
    .perf_cycles(perf_cycles1), .perf_stall(perf_stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one tile on dut from IDLE and check every cycle up to and including DONE.
  task automatic run_tile(input int k, input int stall_row, input int stall_n,
                          input bit poke, input string tag);
    int first_dr, done_c, row, stalled, e_fk;
    bit e_dv;
    logic [23:0] obs, expv;
    first_dr = 2 + k + F0;
    done_c   = first_dr + ROWS0 + stall_n;
    row      = 0;
    stalled  = 0;
    start = 1'b1; k_len = 16'(k);
    tick();
    start = 1'b0; k_len = 16'(k + 7);   // must not affect the running tile
    for (int c = 1; c <= done_c; c++) begin
      e_dv = (c >= first_dr) && (c < done_c);
      if (c < 2) e_fk = 0;
      else if (c <= k + 1) e_fk = c - 2;
      else e_fk = (k > 0) ? k - 1 : 0;
      expv = {1'b1, (c == 1), (c >= 2 && c <= k + 1), (c == done_c), e_dv,
              (e_dv && row == ROWS0 - 1), (e_dv ? 2'(row) : 2'd0), 16'(e_fk)};
      obs  = {busy, acc_clr, feed_en, done, drain_valid, drain_last,
              (drain_valid ? drain_row_sel : 2'd0), feed_k};
      chk($sformatf("%s_c%0d", tag, c), 32'(obs), 32'(expv));
      start = poke && (c == 3 || c == done_c);
      if (e_dv && row == stall_row && stalled < stall_n) begin
        drain_ready = 1'b0;
        stalled++;
      end else begin
        drain_ready = 1'b1;
        if (e_dv) row++;
      end
      tick();
    end
    start = 1'b0; drain_ready = 1'b1;
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_perf_cycles"}, perf_cycles, PERF ? 32'(done_c) : 32'd0);
    chk({tag, "_perf_stall"}, perf_stall, PERF ? 32'(stall_n) : 32'd0);
  endtask

  initial begin
    int first1, done_c1, nfeed1, ndrain1;
    rst_n = 1'b0; start = 1'b0; k_len = 16'd0; drain_ready = 1'b1;
    start1 = 1'b0; k_len1 = 16'd0; drain_ready1 = 1'b1;
    #3;
    chk("reset_outs", {8'd0, busy, acc_clr, feed_en, done, drain_valid, drain_last, drain_row_sel, feed_k}, 32'd0);
    chk("reset_perf", perf_cycles | perf_stall, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_tile(3, -1, 0, 1'b0, "k3");
    run_tile(0, -1, 0, 1'b0, "k0");
    run_tile(5, 2, 3, 1'b1, "k5_stall");
    run_tile(2, -1, 0, 1'b0, "b2b");     // launched in the IDLE cycle right after DONE

    // Asynchronous reset in FLUSH.
    start = 1'b1; k_len = 16'd2;
    tick();
    start = 1'b0;
    repeat (5) tick();                  // cycle 6 is inside FLUSH (cycles 4..11)
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {8'd0, busy, acc_clr, feed_en, done, drain_valid, drain_last, drain_row_sel, feed_k}, 32'd0);
    chk("rst_async_perf", perf_cycles | perf_stall, 32'd0);
    repeat (3) begin
      tick();
      chk("rst_hold", {30'd0, busy, done}, 32'd0);
    end
    #2 rst_n = 1'b1;
    tick();
    chk("rst_release_idle", {30'd0, busy, done}, 32'd0);
    run_tile(1, -1, 0, 1'b0, "post_rst");

    // 2x8 array without the PE input stage: F = 9.
    first1 = 0; done_c1 = 0; nfeed1 = 0; ndrain1 = 0;
    start1 = 1'b1; k_len1 = 16'd4;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (drain_valid1 && first1 == 0) first1 = c;
      if (done1 && done_c1 == 0) done_c1 = c;
      if (feed_en1) nfeed1++;
      if (drain_valid1) ndrain1++;
      tick();
    end
    chk("p0_first_drain", 32'(first1), 32'd15);
    chk("p0_done_cycle", 32'(done_c1), 32'd17);
    chk("p0_feed_cycles", 32'(nfeed1), 32'd4);
    chk("p0_drain_beats", 32'(ndrain1), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/opt1_os_tile_ctrl.md
# opt1_os_tile_ctrl

Tile sequencer for the OPT1 output-stationary systolic array of `ROWS`x`COLS` Booth/CSA MAC PEs. It accepts one tile command (reduction length `k_len`), clears the PE sum/carry accumulators and gates operand streaming for `k_len` cycles. It then waits out the array skew and the PE input pipeline, and drains the array one row per handshake to the downstream carry-propagate/writeback stage. It is a pure control block: it never touches operand or accumulator data.

## Interface
Parameters:
- `ROWS`, default 4: PE rows; drain beats per tile.
- `COLS`, default 4: PE columns; used for the skew flush length.
- `K_WIDTH`, default 16: width of `k_len` and `feed_k`.
- `INPUT_PIP`, default 1: must match the PE `INPUT_PIP` setting (0 or 1); adds that many flush cycles.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: tile command strobe; sampled only in IDLE.
- `k_len`, input, `K_WIDTH`: reduction length; captured with `start`.
- `busy`, output, 1: high in every state except IDLE.
- `acc_clr`, output, 1: high for exactly one cycle (CLEAR); drives the PE accumulator clear, inverted to the PE reset upstream.
- `feed_en`, output, 1: operand skew buffers stream real data when high and inject zeros when low.
- `feed_k`, output, `K_WIDTH`: k index of the operand slice being fed.
- `drain_valid`, output, 1: a row result is presented.
- `drain_ready`, input, 1: downstream accepts the row.
- `drain_row_sel`, output, `clog2(ROWS)`: row muxed onto the drain bus.
- `drain_last`, output, 1: asserted with the final row (`ROWS-1`).
- `done`, output, 1: one-cycle pulse when the tile completes.
- `perf_cycles`, output, 32: see Configuration.
- `perf_stall`, output, 32: see Configuration.

## Operation
- Moore FSM with states IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. All outputs are registered or decoded from state and counters only.
- Reset (async): state IDLE; all outputs and counters 0.
- IDLE:
  - `start=1` captures `k_len` and moves to CLEAR.
  - `start` is ignored in every other state, with no queueing.
- CLEAR: `acc_clr=1` for one cycle.
  - Goes to FEED if captured `k_len!=0`; otherwise skips directly to FLUSH.
- FEED: `feed_en=1`, `feed_k` counts 0..`k_len-1`, one per cycle; goes to FLUSH after the cycle where `feed_k==k_len-1`.
- FLUSH:
  - `feed_en=0`, so zeros are injected; accumulators keep adding 0 and stay stable.
  - Lasts F = `ROWS+COLS-1+INPUT_PIP` cycles, then goes to DRAIN.
- DRAIN:
  - `drain_valid=1`; `drain_row_sel` starts at 0.
  - Advances by one on each cycle with `drain_valid&&drain_ready`.
  - `drain_row_sel` holds stable while `drain_ready=0`.
  - `drain_last=1` while `drain_row_sel==ROWS-1`; its handshake moves to DONE.
- DONE: `done=1` for one cycle, then IDLE. `start` is ignored in DONE and may be accepted on the following IDLE cycle.
- `feed_k` holds its last value after FEED and returns to 0 in CLEAR.
- `k_len` is captured once; later changes to the input do not affect a running tile.
- `rst_n` low mid-tile returns the FSM to IDLE immediately, with all outputs 0. Partial drains are discarded and no `done` pulse is produced.

## Timing
- `start` seen at edge 0: CLEAR in cycle 1, FEED in cycles 2..`k_len+1`, FLUSH for the next F cycles, first `drain_valid` in cycle `2+k_len+F`.
- With no backpressure, `done` asserts in cycle `2+k_len+F+ROWS`.
- Each cycle of `drain_ready=0` during DRAIN delays `done` by one cycle.
- Back-to-back tiles have a minimum gap of one IDLE cycle between `done` and the next CLEAR.

## Configuration
- `OPT1_TILE_CTRL_PERF_CNT_EN` defined:
  - `perf_cycles` latches, at DONE, the number of non-IDLE cycles of that tile, CLEAR through DONE inclusive.
  - `perf_stall` latches the number of DRAIN cycles with `drain_valid&&!drain_ready`.
  - Both hold until the next DONE; reset value 0.
- Macro undefined: the counters are not built; both ports are tied to 0.

## Test plan
- ROWS=COLS=4, INPUT_PIP=1, `k_len=3`, `drain_ready=1` -> `acc_clr` in cycle 1; `feed_k`=0,1,2 in cycles 2-4; `drain_valid` in cycles 13-16 with rows 0-3; `done` in cycle 17; `perf_cycles=17`, `perf_stall=0`.
- `k_len=0` -> no `feed_en`; first `drain_valid` in cycle 10; `done` in cycle 14.
- `k_len=5` with `drain_ready` low for 3 cycles on row 2 -> `drain_row_sel` holds at 2 for 4 cycles; `done` is 3 cycles late; `perf_stall=3`.
- `start` pulsed during FEED and again in the DONE cycle -> both ignored; `start` in the next IDLE cycle launches CLEAR on the following cycle.
- `rst_n` asserted in FLUSH -> all outputs 0 asynchronously; no `done`. A fresh `start` after release runs a complete tile.
- INPUT_PIP=0, ROWS=2, COLS=8, `k_len=4` -> F=9; `done` in cycle 17.
